uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
// PURPOSE
//  Transmit-side buffer that sits directly upstream of UART_TX. The AXI-Lite register block writes bytes in.
//  This block presents the head byte and an active-low start request to UART_TX.
//  It pops the byte when UART_TX pulses tx_get_data. It also exposes level and sticky error flags for the status register.
// PARAMETERS
//  DATA_W    8   byte width; matches UART_TX d_in
//  DEPTH     16  entries; power of two, >= 2
//  AF_LEVEL  12  almost_full asserts when count >= AF_LEVEL
//  (local) ADDR_W = $clog2(DEPTH); CNT_W = ADDR_W+1
// PORTS
//  clk          in   1       system clock, 50 MHz
//  a_resetn     in   1       reset; synchronous, active-high (name kept, polarity fixed high)
//  wr_en        in   1       push wr_data this cycle
//  wr_data      in   DATA_W  byte from register block
//  flush        in   1       one-cycle pulse: empty the FIFO
//  clr_flags    in   1       one-cycle pulse: clear overflow/underflow
//  tx_enable    in   1       1 = allow new frames to be launched
//  tx_get_data  in   1       from UART_TX: head byte latched, pop
//  tx_start     out  1       to UART_TX, active-low: 0 = byte available
//  d_out        out  DATA_W  to UART_TX d_in: head byte
//  empty/full   out  1       level flags
//  almost_full  out  1       count >= AF_LEVEL
//  count        out  CNT_W   occupancy, 0..DEPTH
//  overflow     out  1       sticky: push while full dropped
//  underflow    out  1       sticky: tx_get_data while empty
// BEHAVIOUR
//  Reset (a_resetn=1 at a clk edge): pointers=0, count=0, empty=1, full=0, almost_full=0.
//    Also tx_start=1, d_out=0, overflow=0, underflow=0. Storage contents are don't-care.
//  Reset mid-operation: the FIFO is discarded and tx_start returns to 1 on the next cycle.
//    A frame already inside UART_TX finishes on its own. A tx_get_data pulse during reset is ignored.
//  Push: wr_en & !full -> mem[wr_ptr]<=wr_data; wr_ptr++ wraps DEPTH-1 -> 0.
//  Push while full with no pop: byte dropped, overflow<=1, count unchanged.
//  Pop: tx_get_data & !empty -> rd_ptr++ (wraps). tx_get_data & empty -> no change, underflow<=1.
//  Simultaneous push and pop:
//    - when full: both are performed and count stays DEPTH;
//    - when empty: the pop is an underflow and the push is performed.
//  count/empty/full/almost_full are registered and reflect the post-edge state. No bypass:
//    a byte written at edge N gives empty=0 after edge N; tx_start can fall after edge N+1.
//  tx_start is registered: tx_start <= !(tx_enable & !empty_next & !pop_pending).
//    - pop_pending is set when tx_start is 0 and tx_start is seen low by UART_TX.
//      It is set on the cycle after tx_start=0 is presented and cleared by tx_get_data.
//    - Purpose: tx_start goes back to 1 while UART_TX holds a byte, so a second frame is not launched before the pop.
//  d_out = mem[rd_ptr], registered head. It must be stable whenever tx_start=0 and until the pop edge.
//  tx_enable=0: no new tx_start falls; a pending tx_get_data is still honoured.
//  flush: pointers and count go to 0, tx_start goes to 1, pop_pending clears. Flags are unaffected.
//    flush has priority over push and pop in the same cycle (that push is lost without an overflow).
//    a_resetn has priority over everything.
//  clr_flags: clears both sticky flags. A new error in the same cycle wins, so the flag stays 1.
//  count arithmetic is CNT_W wide; it never exceeds DEPTH and never goes below 0.
// STRUCTURE
//  Package uart_pkg holds:
//    - DATA_W default;
//    - parity encodings (2'b01 odd, 2'b10 even) shared with UART_TX and UART_RX;
//    - the FIFO depth and level constants used by the register map.
//  Sub-module uart_sync_fifo: generic storage, pointers, count and full/empty with sticky errors.
//  This top level adds the UART_TX handshake (tx_start, pop_pending, tx_enable) and almost_full.
// TESTING
//  1 Reset then idle: a_resetn=1 for 2 cycles -> tx_start=1, empty=1, count=0, all flags 0.
//  2 Single byte: write 0xA5 with tx_enable=1 -> tx_start=0 by edge N+2 and d_out=0xA5.
//    After one tx_get_data pulse: empty=1, tx_start=1, no second launch.
//  3 Fill and wrap: write 16 bytes 0x00..0x0F -> full=1, count=16, almost_full from count=12.
//    17th write 0xFF -> dropped, overflow=1. Drain with UART_TX attached: serial order 0x00..0x0F.
//    Refill 4 bytes: pointer wrap gives correct order.
//  4 Simultaneous push and pop at full: count stays 16; the new byte appears last.
//  5 Underflow: tx_get_data pulse while empty -> underflow=1, count=0.
//    clr_flags -> underflow=0. clr_flags together with a new underflow -> underflow stays 1.
//  6 Flush mid-transfer: 5 bytes queued, flush while UART_TX is in its data state.
//    Result: count=0 and tx_start=1; the current frame completes and no further frame starts.
//    Repeat the scenario with reset in place of flush.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants: byte width, parity encodings and TX FIFO sizing used by the register map.
package uart_pkg;

    localparam int unsigned UART_DATA_W = 8;

    // Parity encodings common to UART_TX and UART_RX
    typedef enum logic [1:0] {
        ParityNone = 2'b00,
        ParityOdd  = 2'b01,
        ParityEven = 2'b10
    } parity_e;

    localparam int unsigned UART_FIFO_DEPTH    = 16;
    localparam int unsigned UART_FIFO_AF_LEVEL = 12;

    function automatic int unsigned fifo_cnt_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Generic synchronous FIFO with registered head byte, level flags and sticky overflow/underflow.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   wr_en,
    input  logic [DATA_W-1:0]      wr_data,
    input  logic                   rd_en,
    input  logic                   clr_flags,
    output logic [DATA_W-1:0]      rd_data,
    output logic [$clog2(DEPTH):0] count,
    output logic [$clog2(DEPTH):0] count_next,
    output logic                   empty,
    output logic                   empty_next,
    output logic                   full,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W  = fifo_cnt_w(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              empty_q, empty_d;
    logic              full_q, full_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              push, pop, ovf_set, udf_set;

    always_comb begin
        push    = 1'b0;
        pop     = 1'b0;
        ovf_set = 1'b0;
        udf_set = 1'b0;
        // Flush swallows any same-cycle push or pop without raising an error
        if (!flush) begin
            pop     = rd_en & ~empty_q;
            push    = wr_en & (~full_q | pop);
            ovf_set = wr_en & full_q & ~pop;
            udf_set = rd_en & empty_q;
        end

        wr_ptr_d = wr_ptr_q + ADDR_W'(push);
        rd_ptr_d = rd_ptr_q + ADDR_W'(pop);
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end

        empty_d = (count_d == '0);
        full_d  = (count_d == CNT_W'(DEPTH));

        // Writing into the slot that becomes the head: forward the incoming byte
        if (push && (wr_ptr_q == rd_ptr_d)) begin
            rd_data_d = wr_data;
        end else begin
            rd_data_d = mem[rd_ptr_d];
        end

        overflow_d  = (overflow_q & ~clr_flags) | ovf_set;
        underflow_d = (underflow_q & ~clr_flags) | udf_set;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
            rd_data_q   <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            empty_q     <= empty_d;
            full_q      <= full_d;
            rd_data_q   <= rd_data_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data    = rd_data_q;
    assign count      = count_q;
    assign count_next = count_d;
    assign empty      = empty_q;
    assign empty_next = empty_d;
    assign full       = full_q;
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmit buffer: wraps uart_sync_fifo with the UART_TX start/pop handshake and almost_full.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W   = UART_DATA_W,
    parameter int unsigned DEPTH    = UART_FIFO_DEPTH,
    parameter int unsigned AF_LEVEL = UART_FIFO_AF_LEVEL
) (
    input  logic                   clk,
    input  logic                   a_resetn,
    input  logic                   wr_en,
    input  logic [DATA_W-1:0]      wr_data,
    input  logic                   flush,
    input  logic                   clr_flags,
    input  logic                   tx_enable,
    input  logic                   tx_get_data,
    output logic                   tx_start,
    output logic [DATA_W-1:0]      d_out,
    output logic                   empty,
    output logic                   full,
    output logic                   almost_full,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int unsigned CNT_W = fifo_cnt_w(DEPTH);

    logic [CNT_W-1:0] count_next;
    logic             empty_next;
    logic             tx_start_q, tx_start_d;
    logic             pop_pending_q, pop_pending_d;
    logic             almost_full_q, almost_full_d;

    uart_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (a_resetn),
        .flush      (flush),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .rd_en      (tx_get_data),
        .clr_flags  (clr_flags),
        .rd_data    (d_out),
        .count      (count),
        .count_next (count_next),
        .empty      (empty),
        .empty_next (empty_next),
        .full       (full),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    always_comb begin
        pop_pending_d = 1'b0;
        tx_start_d    = 1'b1;
        if (!flush) begin
            // Once a low start has been presented, hold start high until UART_TX pops
            pop_pending_d = (pop_pending_q | ~tx_start_q) & ~tx_get_data;
            // Need the byte both before and after this edge so a fresh write is never bypassed
            tx_start_d    = ~(tx_enable & ~empty & ~empty_next & ~pop_pending_d);
        end
        almost_full_d = (count_next >= CNT_W'(AF_LEVEL));
    end

    always_ff @(posedge clk) begin
        if (a_resetn) begin
            tx_start_q    <= 1'b1;
            pop_pending_q <= 1'b0;
            almost_full_q <= 1'b0;
        end else begin
            tx_start_q    <= tx_start_d;
            pop_pending_q <= pop_pending_d;
            almost_full_q <= almost_full_d;
        end
    end

    assign tx_start    = tx_start_q;
    assign almost_full = almost_full_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a behavioural UART_TX that pops at the end of each frame.
module tb_uart_tx_fifo;

    localparam int FRAME = 12;

    logic       clk;
    logic       a_resetn;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       flush;
    logic       clr_flags;
    logic       tx_enable;
    logic       tx_get_data;
    logic       tx_start;
    logic [7:0] d_out;
    logic       empty;
    logic       full;
    logic       almost_full;
    logic [4:0] count;
    logic       overflow;
    logic       underflow;

    logic       manual_get;
    logic       model_get;
    int         busy;
    logic [7:0] sent[$];
    int         checks;
    int         errors;

    assign tx_get_data = manual_get | model_get;

    uart_tx_fifo dut (
        .clk         (clk),
        .a_resetn    (a_resetn),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .flush       (flush),
        .clr_flags   (clr_flags),
        .tx_enable   (tx_enable),
        .tx_get_data (tx_get_data),
        .tx_start    (tx_start),
        .d_out       (d_out),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // UART_TX model: launches on a low start while idle, latches d_out, pops at frame end
    always @(negedge clk) begin
        model_get = 1'b0;
        if (busy != 0) begin
            busy = busy - 1;
            if (busy == 0) model_get = 1'b1;
        end else if (tx_start === 1'b0) begin
            sent.push_back(d_out);
            busy = FRAME;
        end
    end

    task automatic wait_drain(input string name);
        int n = 0;
        while (!(empty === 1'b1 && busy == 0 && tx_start === 1'b1) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 2000) begin
            errors++;
            $display("FAIL %s drain timeout count=%0d", name, count);
        end
    endtask

    task automatic write_byte(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic test_reset;
        a_resetn   = 1'b1;
        manual_get = 1'b1;
        repeat (2) @(negedge clk);
        a_resetn   = 1'b0;
        manual_get = 1'b0;
        checks++;
        if ({tx_start, empty, full, almost_full, overflow, underflow} !== 6'b110000) begin
            errors++;
            $display("FAIL reset_flags got %b exp 110000",
                     {tx_start, empty, full, almost_full, overflow, underflow});
        end
        checks++;
        if (count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
        checks++;
        if (d_out !== 8'h00) begin errors++; $display("FAIL reset_dout got %h exp 00", d_out); end
    endtask

    task automatic test_single;
        sent.delete();
        tx_enable = 1'b1;
        write_byte(8'hA5);
        checks++;
        if (empty !== 1'b0 || count !== 5'd1 || tx_start !== 1'b1) begin
            errors++;
            $display("FAIL single_edgeN got empty=%b count=%0d start=%b exp 0 1 1",
                     empty, count, tx_start);
        end
        @(negedge clk);
        checks++;
        if (tx_start !== 1'b0 || d_out !== 8'hA5) begin
            errors++;
            $display("FAIL single_launch got start=%b d_out=%h exp 0 a5", tx_start, d_out);
        end
        wait_drain("single");
        repeat (20) @(negedge clk);
        checks++;
        if (sent.size() != 1 || tx_start !== 1'b1 || empty !== 1'b1) begin
            errors++;
            $display("FAIL single_once got frames=%0d start=%b empty=%b exp 1 1 1",
                     sent.size(), tx_start, empty);
        end else begin
            checks++;
            if (sent[0] !== 8'hA5) begin
                errors++;
                $display("FAIL single_byte got %h exp a5", sent[0]);
            end
        end
        tx_enable = 1'b0;
    endtask

    task automatic test_fill_wrap;
        for (int i = 0; i < 16; i++) begin
            write_byte(8'(i));
            checks++;
            if (count !== 5'(i + 1) || almost_full !== (i + 1 >= 12) || full !== (i == 15)) begin
                errors++;
                $display("FAIL fill_%0d got count=%0d af=%b full=%b exp %0d %b %b", i, count,
                         almost_full, full, i + 1, (i + 1 >= 12), (i == 15));
            end
        end
        write_byte(8'hFF);
        checks++;
        if (overflow !== 1'b1 || count !== 5'd16 || full !== 1'b1) begin
            errors++;
            $display("FAIL overflow got ovf=%b count=%0d full=%b exp 1 16 1",
                     overflow, count, full);
        end
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", overflow); end
        sent.delete();
        tx_enable = 1'b1;
        wait_drain("fill");
        checks++;
        if (sent.size() != 16) begin
            errors++;
            $display("FAIL fill_frames got %0d exp 16", sent.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (sent[i] !== 8'(i)) begin
                    errors++;
                    $display("FAIL fill_order_%0d got %h exp %h", i, sent[i], 8'(i));
                end
            end
        end
        tx_enable = 1'b0;
        for (int i = 0; i < 4; i++) write_byte(8'h20 + 8'(i));
        sent.delete();
        tx_enable = 1'b1;
        wait_drain("refill");
        checks++;
        if (sent.size() != 4) begin
            errors++;
            $display("FAIL refill_frames got %0d exp 4", sent.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (sent[i] !== 8'h20 + 8'(i)) begin
                    errors++;
                    $display("FAIL refill_order_%0d got %h exp %h", i, sent[i], 8'h20 + 8'(i));
                end
            end
        end
        tx_enable = 1'b0;
    endtask

    task automatic test_push_pop_full;
        for (int i = 0; i < 16; i++) write_byte(8'h30 + 8'(i));
        wr_en      = 1'b1;
        wr_data    = 8'h40;
        manual_get = 1'b1;
        @(negedge clk);
        wr_en      = 1'b0;
        manual_get = 1'b0;
        checks++;
        if (count !== 5'd16 || full !== 1'b1 || overflow !== 1'b0 || d_out !== 8'h31) begin
            errors++;
            $display("FAIL pushpop_full got count=%0d full=%b ovf=%b d_out=%h exp 16 1 0 31",
                     count, full, overflow, d_out);
        end
        sent.delete();
        tx_enable = 1'b1;
        wait_drain("pushpop");
        checks++;
        if (sent.size() != 16) begin
            errors++;
            $display("FAIL pushpop_frames got %0d exp 16", sent.size());
        end else begin
            checks++;
            if (sent[0] !== 8'h31 || sent[14] !== 8'h3F || sent[15] !== 8'h40) begin
                errors++;
                $display("FAIL pushpop_order got %h %h %h exp 31 3f 40",
                         sent[0], sent[14], sent[15]);
            end
        end
        tx_enable = 1'b0;
    endtask

    task automatic test_underflow;
        manual_get = 1'b1;
        @(negedge clk);
        manual_get = 1'b0;
        checks++;
        if (underflow !== 1'b1 || count !== 5'd0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL underflow got udf=%b count=%0d empty=%b exp 1 0 1",
                     underflow, count, empty);
        end
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
        checks++;
        if (underflow !== 1'b0) begin errors++; $display("FAIL udf_clear got %b exp 0", underflow); end
        clr_flags  = 1'b1;
        manual_get = 1'b1;
        @(negedge clk);
        clr_flags  = 1'b0;
        manual_get = 1'b0;
        checks++;
        if (underflow !== 1'b1) begin
            errors++;
            $display("FAIL udf_clr_collide got %b exp 1", underflow);
        end
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
    endtask

    // use_reset selects reset instead of flush as the abort mechanism
    task automatic test_abort(input bit use_reset);
        int n = 0;
        for (int i = 0; i < 5; i++) write_byte(8'h50 + 8'(i));
        sent.delete();
        tx_enable = 1'b1;
        while (busy == 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 50) begin errors++; $display("FAIL abort_launch timeout use_reset=%0d", use_reset); end
        repeat (4) @(negedge clk);
        if (use_reset) a_resetn = 1'b1;
        else flush = 1'b1;
        @(negedge clk);
        a_resetn = 1'b0;
        flush    = 1'b0;
        checks++;
        if (count !== 5'd0 || empty !== 1'b1 || tx_start !== 1'b1) begin
            errors++;
            $display("FAIL abort_state rst=%0d got count=%0d empty=%b start=%b exp 0 1 1",
                     use_reset, count, empty, tx_start);
        end
        if (use_reset) begin
            checks++;
            if (d_out !== 8'h00) begin errors++; $display("FAIL abort_dout got %h exp 00", d_out); end
        end
        n = 0;
        while (busy != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (20) @(negedge clk);
        checks++;
        if (sent.size() != 1 || tx_start !== 1'b1) begin
            errors++;
            $display("FAIL abort_frames rst=%0d got frames=%0d start=%b exp 1 1",
                     use_reset, sent.size(), tx_start);
        end else begin
            checks++;
            if (sent[0] !== 8'h50) begin
                errors++;
                $display("FAIL abort_byte got %h exp 50", sent[0]);
            end
        end
        tx_enable = 1'b0;
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        busy       = 0;
        model_get  = 1'b0;
        manual_get = 1'b0;
        a_resetn   = 1'b1;
        wr_en      = 1'b0;
        wr_data    = 8'h00;
        flush      = 1'b0;
        clr_flags  = 1'b0;
        tx_enable  = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_fill_wrap();
        test_push_pop_full();
        test_underflow();
        test_abort(1'b0);
        test_abort(1'b1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
